booth_multiplier: RTL and testbench

- Sequential signed 8x8 radix-2 Booth multiplier, downstream of module_control.
- Consumes its two 8-bit two's-complement operands (numero1_o, numero2_o) and its valid flag.
- Produces a registered 16-bit signed product for the result display/BCD conversion stage.
- One Booth iteration per clock; product available 8 cycles after start is accepted.

---
 rtl/booth_multiplier.sv | 110 +++++++++++
 tb/tb_booth_multiplier.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: one Booth iteration per clock,
// registered 2N-bit product with a one-cycle done pulse.
module booth_multiplier #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  input  logic [N-1:0]   numero1_i,
  input  logic [N-1:0]   numero2_i,
  output logic [2*N-1:0] producto_o,
  output logic           done_o,
  output logic           busy_o
);

  localparam int unsigned AW = N + 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] a;
  logic [AW-1:0] mx;
  logic [N-1:0]  q;
  logic          q_1;
  logic [CW-1:0] count;
  logic          valid_prev;
  // Cleared by reset; a start needs valid_i to have been seen low since then.
  logic          armed;

  logic          start_c;
  logic [AW-1:0] a_sum_c;
  logic [AW-1:0] a_next_c;
  logic [N-1:0]  q_next_c;
  logic          q_1_next_c;

  assign start_c = valid_i & ~valid_prev & armed & (state == IDLE);

  // Booth add/subtract followed by the arithmetic right shift of {A,Q,Q_1}.
  always_comb begin
    a_sum_c = a;
    unique case ({q[0], q_1})
      2'b01:   a_sum_c = a + mx;
      2'b10:   a_sum_c = a - mx;
      default: a_sum_c = a;
    endcase
    {a_next_c, q_next_c, q_1_next_c} = {a_sum_c[AW-1], a_sum_c, q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      a          <= '0;
      mx         <= '0;
      q          <= '0;
      q_1        <= 1'b0;
      count      <= '0;
      valid_prev <= 1'b0;
      armed      <= 1'b0;
      producto_o <= '0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      valid_prev <= valid_i;
      if (!valid_i) begin
        armed <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start_c) begin
            mx     <= {numero1_i[N-1], numero1_i};
            q      <= numero2_i;
            a      <= '0;
            q_1    <= 1'b0;
            count  <= '0;
            busy_o <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          a     <= a_next_c;
          q     <= q_next_c;
          q_1   <= q_1_next_c;
          count <= count + CW'(1);
          if (count == LAST_COUNT) begin
            producto_o <= {a_next_c[N-1:0], q_next_c};
            done_o     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against a plain signed-multiply model.
module tb_booth_multiplier;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  numero1_i;
  logic [7:0]  numero2_i;
  logic [15:0] producto_o;
  logic        done_o;
  logic        busy_o;

  int tests_run;
  int tests_failed;

  booth_multiplier #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .numero1_i (numero1_i),
    .numero2_i (numero2_i),
    .producto_o(producto_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_product(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    return 16'(sx * sy);
  endfunction

  // Drive one multiplication and observe latency, pulse count and busy length.
  task automatic run_mult(input logic [7:0] x, input logic [7:0] y, input bit hold,
                          output logic [15:0] p, output int lat, output int pulses,
                          output int busy_cycles);
    @(negedge clk);
    numero1_i = x;
    numero2_i = y;
    valid_i   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid_i = 1'b0;
    busy_cycles = busy_o ? 1 : 0;
    lat    = -1;
    pulses = 0;
    p      = 16'hxxxx;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (busy_o) busy_cycles++;
      if (done_o) begin
        pulses++;
        if (lat < 0) lat = k;
        p = producto_o;
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid_i = 1'b0;
    numero1_i = 8'h00;
    numero2_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (producto_o !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_product got %h want 0000", producto_o);
    end
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got done=%b busy=%b want 0 0", done_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_mult(input string name, input logic [7:0] x, input logic [7:0] y,
                            input bit hold);
    logic [15:0] p;
    int lat, pulses, busy_cycles;
    run_mult(x, y, hold, p, lat, pulses, busy_cycles);
    tests_run++;
    if (p !== ref_product(x, y)) begin
      tests_failed++;
      $display("FAIL %s_product got %h want %h", name, p, ref_product(x, y));
    end
    tests_run++;
    if (lat != 8 || pulses != 1) begin
      tests_failed++;
      $display("FAIL %s_done got latency=%0d pulses=%0d want 8 1", name, lat, pulses);
    end
    tests_run++;
    if (busy_cycles != 9) begin
      tests_failed++;
      $display("FAIL %s_busy got %0d cycles want 9", name, busy_cycles);
    end
  endtask

  task automatic test_basic_hold();
    check_mult("m7xm7_hold", 8'h07, 8'hF9, 1'b1);
  endtask

  task automatic test_corners();
    check_mult("m128xm128", 8'h80, 8'h80, 1'b0);
    check_mult("p127xm128", 8'h7F, 8'h80, 1'b0);
    check_mult("zero", 8'h00, 8'h55, 1'b0);
    check_mult("m1xm1", 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic test_input_change();
    int pulses;
    logic [15:0] p;
    @(negedge clk);
    numero1_i = 8'h07;
    numero2_i = 8'hF9;
    valid_i   = 1'b1;
    pulses    = 0;
    p         = 16'hxxxx;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        pulses++;
        p = producto_o;
      end
      if (k == 2) begin
        numero1_i = 8'h05;
        numero2_i = 8'h05;
        valid_i   = 1'b0;
      end
      if (k == 4) valid_i = 1'b1;
    end
    tests_run++;
    if (p !== 16'hFFCF || pulses != 1) begin
      tests_failed++;
      $display("FAIL midcalc_change got %h pulses=%0d want FFCF 1", p, pulses);
    end
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_mult("p5xp5", 8'h05, 8'h05, 1'b0);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    numero1_i = 8'h07;
    numero2_i = 8'hF9;
    valid_i   = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if (producto_o !== 16'h0000 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_async got p=%h busy=%b done=%b want 0000 0 0",
               producto_o, busy_o, done_o);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (busy_o || done_o) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL abort_no_restart got %0d active cycles want 0", seen);
    end
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_mult("post_abort", 8'h03, 8'hFC, 1'b0);
  endtask

  task automatic test_random_sweep();
    logic [7:0] x, y;
    logic [15:0] p;
    int lat, pulses, busy_cycles;
    int starts, total_pulses;
    starts = 0;
    total_pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      run_mult(x, y, i[0], p, lat, pulses, busy_cycles);
      starts++;
      total_pulses += pulses;
      tests_run++;
      if (p !== ref_product(x, y) || lat != 8) begin
        tests_failed++;
        $display("FAIL sweep %h*%h got %h lat=%0d want %h lat=8",
                 x, y, p, lat, ref_product(x, y));
      end
    end
    tests_run++;
    if (total_pulses != starts) begin
      tests_failed++;
      $display("FAIL sweep_pulses got %0d want %0d", total_pulses, starts);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic_hold();
    test_corners();
    test_input_change();
    test_abort();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
